// File: rtl/alu_pkg.sv
// Shared definitions for the UART-ALU command sequencer: opcode values,
// state encoding and opcode validation.
package alu_pkg;

  localparam int NB_OP = 6;

  localparam logic [NB_OP-1:0] OP_ADD = 6'b100000;
  localparam logic [NB_OP-1:0] OP_SUB = 6'b100010;
  localparam logic [NB_OP-1:0] OP_AND = 6'b100100;
  localparam logic [NB_OP-1:0] OP_OR  = 6'b100101;
  localparam logic [NB_OP-1:0] OP_XOR = 6'b100110;
  localparam logic [NB_OP-1:0] OP_NOR = 6'b100111;
  localparam logic [NB_OP-1:0] OP_SRA = 6'b000011;
  localparam logic [NB_OP-1:0] OP_SRL = 6'b000010;

  localparam logic [2:0] ST_WAIT_A  = 3'd0;
  localparam logic [2:0] ST_WAIT_B  = 3'd1;
  localparam logic [2:0] ST_WAIT_OP = 3'd2;
  localparam logic [2:0] ST_SEND    = 3'd3;
  localparam logic [2:0] ST_WAIT_TX = 3'd4;

  typedef enum logic [2:0] {
    WAIT_A  = ST_WAIT_A,
    WAIT_B  = ST_WAIT_B,
    WAIT_OP = ST_WAIT_OP,
    SEND    = ST_SEND,
    WAIT_TX = ST_WAIT_TX
  } state_t;

  function automatic logic op_is_valid(input logic [NB_OP-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_is_valid = 1'b1;
      default:                        op_is_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_uart_interface_if.sv
// Bundle between the command sequencer and its UART receiver, transmitter
// and ALU neighbours.
interface alu_uart_interface_if #(
  parameter int DBIT  = 8,
  parameter int NB_OP = 6
);
  logic [DBIT-1:0]  i_rx_data;
  logic             i_rx_done_tick;
  logic [DBIT-1:0]  i_alu_result;
  logic             i_tx_done_tick;
  logic [DBIT-1:0]  o_data_a;
  logic [DBIT-1:0]  o_data_b;
  logic [NB_OP-1:0] o_op;
  logic [DBIT-1:0]  o_tx_data;
  logic             o_tx_start;
  logic             o_busy;
  logic             o_op_error;
  logic             o_timeout;

  // Sequencer side.
  modport slave (
    input  i_rx_data, i_rx_done_tick, i_alu_result, i_tx_done_tick,
    output o_data_a, o_data_b, o_op, o_tx_data, o_tx_start,
           o_busy, o_op_error, o_timeout
  );

  // UART / ALU side.
  modport master (
    output i_rx_data, i_rx_done_tick, i_alu_result, i_tx_done_tick,
    input  o_data_a, o_data_b, o_op, o_tx_data, o_tx_start,
           o_busy, o_op_error, o_timeout
  );
endinterface

// File: rtl/alu_uart_interface.sv
// Collects operand A, operand B and opcode bytes from the UART receiver,
// lets the external ALU evaluate them and hands the result to the transmitter.
module alu_uart_interface
  import alu_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int NB_OP      = alu_pkg::NB_OP,
  parameter int TIMEOUT    = 1_000_000,
  parameter int NB_TIMEOUT = 20
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  alu_uart_interface_if.slave  bus
);

  state_t                state, state_next;
  logic [NB_TIMEOUT-1:0] cnt, cnt_next;
  logic                  load_a, load_b, load_op, send, op_err, tmo, expired;

  logic [DBIT-1:0]  data_a, data_b, tx_data;
  logic [NB_OP-1:0] op;
  logic             tx_start, busy, op_error, timeout;

  assign expired = (state == WAIT_B || state == WAIT_OP) &&
                   (cnt == NB_TIMEOUT'(TIMEOUT - 1));

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    send       = 1'b0;
    op_err     = 1'b0;
    tmo        = 1'b0;
    case (state)
      WAIT_A: if (bus.i_rx_done_tick) begin
        load_a     = 1'b1;
        state_next = WAIT_B;
      end
      WAIT_B: if (bus.i_rx_done_tick) begin
        load_b     = 1'b1;
        state_next = WAIT_OP;
      end else if (expired) begin
        tmo        = 1'b1;
        state_next = WAIT_A;
      end
      WAIT_OP: if (bus.i_rx_done_tick) begin
        if (op_is_valid(bus.i_rx_data[NB_OP-1:0])) begin
          load_op    = 1'b1;
          state_next = SEND;
        end else begin
          op_err     = 1'b1;
          state_next = WAIT_A;
        end
      end else if (expired) begin
        tmo        = 1'b1;
        state_next = WAIT_A;
      end
      SEND: begin
        send       = 1'b1;
        state_next = WAIT_TX;
      end
      WAIT_TX: if (bus.i_tx_done_tick) state_next = WAIT_A;
      default: state_next = WAIT_A;
    endcase

    // Counter restarts on every entry into a byte-wait state and idles at zero.
    if ((state_next == WAIT_B || state_next == WAIT_OP) && state_next == state)
      cnt_next = cnt + NB_TIMEOUT'(1);
    else
      cnt_next = '0;
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      // NOTE: operand and result registers are ordinary flops, so they are
      // reset with everything else and all outputs read 0 after reset.
      state    <= WAIT_A;
      cnt      <= '0;
      data_a   <= '0;
      data_b   <= '0;
      op       <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      op_error <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      if (load_a)  data_a  <= bus.i_rx_data;
      if (load_b)  data_b  <= bus.i_rx_data;
      if (load_op) op      <= bus.i_rx_data[NB_OP-1:0];
      if (send)    tx_data <= bus.i_alu_result;
      tx_start <= send;
      busy     <= (state_next == SEND || state_next == WAIT_TX);
      op_error <= op_err;
      timeout  <= tmo;
    end
  end

  assign bus.o_data_a   = data_a;
  assign bus.o_data_b   = data_b;
  assign bus.o_op       = op;
  assign bus.o_tx_data  = tx_data;
  assign bus.o_tx_start = tx_start;
  assign bus.o_busy     = busy;
  assign bus.o_op_error = op_error;
  assign bus.o_timeout  = timeout;

endmodule
